// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller and its request queue.
package elevator_pkg;

  localparam int unsigned FLOOR_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    CLEAR,
    DOOR_OPEN
  } state_t;

  typedef enum logic [1:0] {
    DIR_IDLE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // SCAN rule: keep heading while requests remain ahead, else reverse, else idle.
  function automatic dir_t scan_dir(input dir_t dir, input logic above, input logic below);
    dir_t d;
    if (dir == DIR_DOWN) d = below ? DIR_DOWN : (above ? DIR_UP : DIR_IDLE);
    else                 d = above ? DIR_UP : (below ? DIR_DOWN : DIR_IDLE);
    return d;
  endfunction

endpackage

// File: rtl/elevator_scan_select.sv
// Combinational request summary relative to the current floor: above / below / here.
module elevator_scan_select
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_COUNT = 7
) (
  input  logic [FLOOR_COUNT-1:0] queue_status,
  input  logic [FLOOR_IDX_W-1:0] cur,
  output logic                   above_c,
  output logic                   below_c,
  output logic                   here_c
);

  always_comb begin
    above_c = 1'b0;
    below_c = 1'b0;
    here_c  = 1'b0;
    for (int unsigned i = 0; i < FLOOR_COUNT; i++) begin
      if (FLOOR_IDX_W'(i) > cur)       above_c = above_c | queue_status[i];
      else if (FLOOR_IDX_W'(i) < cur)  below_c = below_c | queue_status[i];
      else                             here_c  = queue_status[i];
    end
  end

endmodule

// File: rtl/elevator_car_ctrl.sv
// SCAN car controller: picks destinations from the request queue, times travel and doors,
// and writes a clear back for each served floor. ELEV_DOOR_OBSTRUCT_EN adds door_obstruct.
module elevator_car_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOOR_COUNT         = 7,
  parameter int unsigned FLOOR_TRAVEL_CYCLES = 16,
  parameter int unsigned DOOR_OPEN_CYCLES    = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [FLOOR_COUNT-1:0] queue_status,
  output logic                   q_wr_req,
  input  logic                   q_wr_gnt,
  output logic                   q_r_nwr,
  output logic                   q_deassert_floor,
  output logic [FLOOR_IDX_W-1:0] q_floor,
  output logic [FLOOR_IDX_W-1:0] current_floor,
  output logic                   dir_up,
  output logic                   dir_down,
  output logic                   motor_up,
  output logic                   motor_down,
`ifdef ELEV_DOOR_OBSTRUCT_EN
  input  logic                   door_obstruct,
`endif
  output logic                   door_open
);

  localparam int unsigned TIMER_MAX = (FLOOR_TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ?
                                      FLOOR_TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int unsigned PAD_W     = 2 ** FLOOR_IDX_W;
  localparam logic [TIMER_W-1:0]     TRAVEL_LAST = TIMER_W'(FLOOR_TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]     DOOR_LAST   = TIMER_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [FLOOR_IDX_W-1:0] TOP_FLOOR   = FLOOR_IDX_W'(FLOOR_COUNT - 1);

  state_t                 state, state_next;
  dir_t                   dir, dir_next;
  logic [FLOOR_IDX_W-1:0] cur_next;
  logic [TIMER_W-1:0]     timer, timer_next;
  logic                   arrived, arrived_next;
  logic                   step;
  logic                   above, below, here;
  logic                   obstruct;
  logic [PAD_W-1:0]       status_pad;
  logic                   motor_go, door_hold;
  logic                   motor_up_d, motor_down_d, dir_up_d, dir_down_d;
  logic                   q_wr_req_d, door_open_d;

`ifdef ELEV_DOOR_OBSTRUCT_EN
  assign obstruct = door_obstruct;
`else
  assign obstruct = 1'b0;
`endif

  assign status_pad = PAD_W'(queue_status);
  assign q_floor    = current_floor;

  elevator_scan_select #(.FLOOR_COUNT(FLOOR_COUNT)) u_scan (
    .queue_status (queue_status),
    .cur          (current_floor),
    .above_c      (above),
    .below_c      (below),
    .here_c       (here)
  );

  // State, datapath and registered actuator/queue outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      dir              <= DIR_IDLE;
      current_floor    <= '0;
      timer            <= '0;
      arrived          <= 1'b0;
      motor_up         <= 1'b0;
      motor_down       <= 1'b0;
      dir_up           <= 1'b0;
      dir_down         <= 1'b0;
      q_wr_req         <= 1'b0;
      q_r_nwr          <= 1'b1;
      q_deassert_floor <= 1'b0;
      door_open        <= 1'b0;
    end else begin
      state            <= state_next;
      dir              <= dir_next;
      current_floor    <= cur_next;
      timer            <= timer_next;
      arrived          <= arrived_next;
      motor_up         <= motor_up_d;
      motor_down       <= motor_down_d;
      dir_up           <= dir_up_d;
      dir_down         <= dir_down_d;
      q_wr_req         <= q_wr_req_d;
      q_r_nwr          <= !q_wr_req_d;
      q_deassert_floor <= q_wr_req_d;
      door_open        <= door_open_d;
    end
  end

  // Next state; 'arrived' marks the cycle after a floor step where the stop decision is made.
  always_comb begin
    state_next   = state;
    dir_next     = dir;
    cur_next     = current_floor;
    timer_next   = '0;
    arrived_next = 1'b0;
    step         = 1'b0;
    unique case (state)
      IDLE: begin
        dir_next = scan_dir(DIR_IDLE, above, below);
        if (here) begin
          state_next = CLEAR;
          dir_next   = DIR_IDLE;
        end else if (dir_next != DIR_IDLE) begin
          state_next = MOVE;
        end
      end
      MOVE: begin
        if (arrived && here) begin
          state_next = CLEAR;
        end else if (arrived && scan_dir(dir, above, below) == DIR_IDLE) begin
          state_next = IDLE;
          dir_next   = DIR_IDLE;
        end else begin
          if (arrived) dir_next = scan_dir(dir, above, below);
          if (timer == TRAVEL_LAST) begin
            step         = 1'b1;
            arrived_next = 1'b1;
            if (dir_next == DIR_UP && current_floor != TOP_FLOOR)
              cur_next = current_floor + FLOOR_IDX_W'(1);
            else if (dir_next == DIR_DOWN && current_floor != '0)
              cur_next = current_floor - FLOOR_IDX_W'(1);
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end
      end
      CLEAR: begin
        if (q_wr_gnt) state_next = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        if (obstruct) begin
          timer_next = '0;
        end else if (timer == DOOR_LAST) begin
          if (here) begin
            state_next = CLEAR;
          end else begin
            dir_next   = scan_dir(dir, above, below);
            state_next = (dir_next == DIR_IDLE) ? IDLE : MOVE;
          end
        end else begin
          timer_next = timer + TIMER_W'(1);
        end
      end
    endcase
  end

  // Output decode; motor drops already in the decision cycle when the new floor is requested.
  always_comb begin
    door_hold    = (state == DOOR_OPEN) || (state == CLEAR && door_open);
    motor_go     = (state_next == MOVE) && !(step && status_pad[cur_next]);
    motor_up_d   = motor_go && (dir_next == DIR_UP);
    motor_down_d = motor_go && (dir_next == DIR_DOWN);
    dir_up_d     = (dir_next == DIR_UP);
    dir_down_d   = (dir_next == DIR_DOWN);
    q_wr_req_d   = (state_next == CLEAR);
    door_open_d  = (state_next == DOOR_OPEN) || (state_next == CLEAR && door_hold);
  end

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with a small request-queue model on the write port.
`timescale 1ns/1ps
module tb_elevator_car_ctrl;

  localparam int unsigned FC = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [FC-1:0] qs = '0;
  logic [FC-1:0] pulse = '0;
  logic          q_wr_gnt = 1'b1;
  logic          q_wr_req, q_r_nwr, q_deassert_floor;
  logic [2:0]    q_floor, current_floor;
  logic          dir_up, dir_down, motor_up, motor_down, door_open;
`ifdef ELEV_DOOR_OBSTRUCT_EN
  logic          door_obstruct = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int mu_cnt = 0, md_cnt = 0, door_cnt = 0, wr_cnt = 0, excl_viol = 0;
  int b_mu, b_md, b_door, b_wr, b_sv;
  int served[$];

  always #5 clk = ~clk;

  elevator_car_ctrl #(
    .FLOOR_COUNT         (FC),
    .FLOOR_TRAVEL_CYCLES (16),
    .DOOR_OPEN_CYCLES    (32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .queue_status     (qs),
    .q_wr_req         (q_wr_req),
    .q_wr_gnt         (q_wr_gnt),
    .q_r_nwr          (q_r_nwr),
    .q_deassert_floor (q_deassert_floor),
    .q_floor          (q_floor),
    .current_floor    (current_floor),
    .dir_up           (dir_up),
    .dir_down         (dir_down),
    .motor_up         (motor_up),
    .motor_down       (motor_down),
`ifdef ELEV_DOOR_OBSTRUCT_EN
    .door_obstruct    (door_obstruct),
`endif
    .door_open        (door_open)
  );

  // Request queue: new calls OR in, a granted deassert write clears (clear wins on collision).
  always @(posedge clk) begin : queue_model
    logic [7:0] clr8;
    clr8 = '0;
    if (q_wr_req && q_wr_gnt && !q_r_nwr && q_deassert_floor) clr8[q_floor] = 1'b1;
    qs <= (qs | pulse) & ~clr8[FC-1:0];
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (motor_up)   mu_cnt++;
      if (motor_down) md_cnt++;
      if (door_open)  door_cnt++;
      if (q_wr_req && q_wr_gnt) begin
        wr_cnt++;
        served.push_back(int'(q_floor));
      end
      if ((motor_up && motor_down) || (door_open && (motor_up || motor_down)) ||
          (q_wr_req == q_r_nwr) || (q_deassert_floor != q_wr_req) || (dir_up && dir_down))
        excl_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int served_at(input int i);
    return (i < served.size()) ? served[i] : -1;
  endfunction

  task automatic snap();
    b_mu = mu_cnt; b_md = md_cnt; b_door = door_cnt; b_wr = wr_cnt; b_sv = served.size();
  endtask

  task automatic call(input logic [FC-1:0] mask);
    @(posedge clk); #1 pulse = mask;
    @(posedge clk); #1 pulse = '0;
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!(motor_up || motor_down || door_open || q_wr_req) && qs == '0) q++;
      else q = 0;
    end
    check({tag, "_done"}, 32'(q >= 4), 1);
  endtask

  initial begin
    int n, len, post, mot;
    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_q_r_nwr", 32'(q_r_nwr), 1);
    check("rst_outs", 32'({motor_up, motor_down, door_open, q_wr_req, q_deassert_floor,
                           dir_up, dir_down}), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_floor", 32'(current_floor), 0);
    check("idle_outs", 32'({motor_up, motor_down, door_open, q_wr_req, dir_up, dir_down}), 0);
    check("idle_q_r_nwr", 32'(q_r_nwr), 1);

    // single call to floor 3
    snap();
    call(7'b0001000);
    wait_quiet("t2");
    check("t2_motor_up", 32'(mu_cnt - b_mu), 48);
    check("t2_motor_down", 32'(md_cnt - b_md), 0);
    check("t2_floor", 32'(current_floor), 3);
    check("t2_writes", 32'(wr_cnt - b_wr), 1);
    check("t2_wr_floor", 32'(served_at(b_sv)), 3);
    check("t2_door", 32'(door_cnt - b_door), 32);
    check("t2_dir_idle", 32'({dir_up, dir_down}), 0);

    // SCAN from floor 3 with calls at 5 and 1
    snap();
    call(7'b0100010);
    wait_quiet("t3");
    check("t3_motor_up", 32'(mu_cnt - b_mu), 32);
    check("t3_motor_down", 32'(md_cnt - b_md), 64);
    check("t3_writes", 32'(wr_cnt - b_wr), 2);
    check("t3_first", 32'(served_at(b_sv)), 5);
    check("t3_second", 32'(served_at(b_sv + 1)), 1);
    check("t3_door", 32'(door_cnt - b_door), 64);
    check("t3_floor", 32'(current_floor), 1);

    // grant withheld for 10 cycles at floor 4
    @(posedge clk); #1 q_wr_gnt = 1'b0;
    snap();
    call(7'b0010000);
    n = 0;
    do begin @(negedge clk); n++; end while (!q_wr_req && n < 200);
    check("t4_req_seen", 32'(q_wr_req), 1);
    len = 0;
    for (int i = 0; i < 10; i++) begin
      if (!q_r_nwr && q_deassert_floor && q_floor == 3'd4 && !door_open && !motor_up && !motor_down)
        len++;
      @(negedge clk);
    end
    check("t4_hold", 32'(len), 10);
    check("t4_no_write", 32'(wr_cnt - b_wr), 0);
    @(posedge clk); #1 q_wr_gnt = 1'b1;
    @(negedge clk);
    check("t4_door_before", 32'(door_open), 0);
    @(negedge clk);
    check("t4_door_after", 32'(door_open), 1);
    check("t4_released", 32'({q_wr_req, q_r_nwr}), 1);
    wait_quiet("t4");
    check("t4_motor_up", 32'(mu_cnt - b_mu), 48);
    check("t4_wr_floor", 32'(served_at(b_sv)), 4);
    check("t4_writes", 32'(wr_cnt - b_wr), 1);

    // re-call of floor 3 while its door is open
    snap();
    call(7'b0001000);
    n = 0;
    do begin @(negedge clk); n++; end while (!door_open && n < 200);
    len = 0; mot = 0;
    while (door_open && len < 300) begin
      len++;
      if (motor_up || motor_down) mot++;
      if (len == 10) pulse = 7'b0001000;
      else if (len == 11) pulse = '0;
      @(negedge clk);
    end
    check("t5_door_len", 32'(len), 65);
    check("t5_no_motor", 32'(mot), 0);
    check("t5_writes", 32'(wr_cnt - b_wr), 2);
    check("t5_wr_a", 32'(served_at(b_sv)), 3);
    check("t5_wr_b", 32'(served_at(b_sv + 1)), 3);
    wait_quiet("t5");

    // reset mid-travel near floor 2
    call(7'b0000001);
    n = 0;
    do begin @(negedge clk); n++; end while (current_floor != 3'd2 && n < 200);
    repeat (3) @(negedge clk);
    check("t6_moving", 32'({motor_up, motor_down}), 1);
    @(posedge clk); #2 reset_n = 1'b0; #1;
    check("t6_rst_outs", 32'({motor_up, motor_down, door_open, q_wr_req, dir_up, dir_down}), 0);
    check("t6_rst_floor", 32'(current_floor), 0);
    check("t6_rst_q_r_nwr", 32'(q_r_nwr), 1);
    check("t6_queue_kept", 32'(qs), 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    snap();
    wait_quiet("t6");
    check("t6_no_motion", 32'((mu_cnt - b_mu) + (md_cnt - b_md)), 0);
    check("t6_wr_floor", 32'(served_at(b_sv)), 0);
    check("t6_writes", 32'(wr_cnt - b_wr), 1);

`ifdef ELEV_DOOR_OBSTRUCT_EN
    // obstruction holds the door; closes a full door period after release
    call(7'b0000100);
    n = 0;
    do begin @(negedge clk); n++; end while (!door_open && n < 200);
    len = 0; post = 0;
    while (door_open && len < 300) begin
      len++;
      if (len == 5)  door_obstruct = 1'b1;
      if (len == 25) door_obstruct = 1'b0;
      if (len >= 25) post++;
      @(negedge clk);
    end
    check("obs_after_release", 32'(post), 32);
    check("obs_total", 32'(len), 56);
    wait_quiet("obs");
`else
    post = 0;
`endif

    check("exclusive", 32'(excl_viol), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
